pic_nchan: RTL and testbench
============================

Name: pic_nchan

Overview:
- Clocked, parametrised successor to the 8259-style PIC, with NUM_IRQ channels (default 16).
- Provides per-channel edge/level trigger, mask (IMR), request (IRR) and in-service (ISR) registers, fully-nested priority, optional rotating priority and auto-EOI.
- Sits between peripheral irq lines and the CPU register bus; answers the two-pulse inta_n acknowledge sequence with a vector.

Parameters:
- NUM_IRQ, 16, interrupt channel count (2..DATA_W).
- DATA_W, 16, register bus width; NUM_IRQ <= DATA_W.
- VEC_W, 8, vector width; vector = {vec_base[VEC_W-1:ID_W], channel id}, ID_W = $clog2(NUM_IRQ).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cs_n  in  1  chip select, active low.
- wr_n  in  1  write strobe, active low, sampled on clk.
- rd_n  in  1  read strobe, active low, sampled on clk.
- addr  in  3  register address.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  registered read data.
- irq  in  NUM_IRQ  asynchronous interrupt request lines.
- inta_n  in  1  interrupt acknowledge, active low.
- int_o  out  1  interrupt request to CPU.
- vec_out  out  VEC_W  acknowledge vector.
- vec_valid  out  1  vec_out valid.

Behaviour:
- Reset (async): IRR=ISR=0, IMR=all ones, TRIG=0 (edge), CTRL=0, vec_base=0, rotation pointer=0, FSM=IDLE. int_o, vec_valid, vec_out and data_out are all 0.
- Register map:
  - 0 CTRL RW: [0] aeoi, [1] rotate.
  - 1 VECBASE RW: upper VEC_W-ID_W bits used.
  - 2 IMR RW.
  - 3 TRIG RW: 1 = level.
  - 4 IRR RO.
  - 5 ISR RO.
  - 6 EOI WO: data_in[DATA_W-1]=1 is non-specific; else specific, channel data_in[ID_W-1:0].
  - 7 SWINT WO (optional feature).
- Bus access: write when cs_n=0 and wr_n=0. Read when cs_n=0, rd_n=0, wr_n=1; data_out updates the next cycle and holds otherwise. wr and rd together: write only. Unused bits of a NUM_IRQ-wide register read 0.
- irq synchronisation: 2-FF synchroniser per line.
  - Edge mode: synced 0->1 sets IRR.
  - Level mode: IRR = synced level, except while the channel is being acknowledged.
- Priority:
  - Fixed: channel 0 highest.
  - Rotate=1: the channel after the rotation pointer is highest. An EOI of channel k sets pointer=k (k becomes lowest).
- int_o (registered) = 1 when the highest-priority bit of IRR&~IMR outranks every ISR bit (fully nested); 0 otherwise.
- Acknowledge FSM, advanced on synced inta_n falling edges:
  - IDLE --fall--> ACK1: latch winner W. If W exists: set ISR[W], clear IRR[W] (edge), int_o=0. If none (request vanished or was masked): spurious, W=NUM_IRQ-1, ISR untouched.
  - ACK1 --fall--> ACK2: vec_out={base,W}, vec_valid=1 until inta_n rises. On that rise, ISR[W] is cleared if aeoi=1 and not spurious; then IDLE.
  - inta_n falling in IDLE with int_o=0 is still handled as spurious.
- EOI: non-specific clears the highest-priority ISR bit; specific clears ISR[k]; with ISR=0 it is a no-op. Same-cycle ACK1 set and EOI: EOI targets pre-cycle ISR; ISR_next=(ISR|set)&~clr.
- IMR change mid-ACK does not change latched W.
- Reset mid-sequence returns to IDLE immediately and drops vec_valid.

Optional Feature:
- PIC_SWINT_EN defined: address 7 write ORs data_in[NUM_IRQ-1:0] into IRR, for all channels including level-mode ones (cleared on ack).
- Undefined: address 7 writes are ignored; no SWINT logic is synthesised.

Decomposition:
- Package pic_pkg: register address constants, ack FSM state enum (IDLE, ACK1, ACK2), CTRL bit indices.
- Sub-module pic_prio_resolver: combinational; IRR&~IMR, ISR, rotation pointer in; winner id, valid and outranks-ISR flag out.
- Instantiated twice: once for requests, once for ISR (EOI target).

Test Plan:
- Fixed priority: unmask all, irq pulse 0x0012, vec_base=0x70 -> int_o=1; first inta -> ISR=0x0002, IRR=0x0010; second inta -> vec_out=0x71; non-specific EOI -> ISR=0, int_o reasserts, next vector 0x74.
- Mask/readback: IMR=0x00C2, irq=0x0096 -> IRR reads 0x0096, int_o for ch2 only, IMR reads 0x00C2.
- Auto-EOI+level: TRIG=0x0001, aeoi=1, hold irq[0] -> vector 0x70, ISR=0 after inta rises, int_o re-asserts while irq[0] high.
- Rotate: rotate=1, service ch1, EOI, then irq 0x0003 -> ch0 serviced before ch1 only after pointer update (vector 0x70 first).
- Spurious: unmasked irq[3] edge, set IMR bit3 before inta -> vector {base,15}, ISR=0.
- Reset mid-ACK: assert rst_n=0 between inta pulses -> vec_valid=0, IRR=ISR=0, IMR=0xFFFF.

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg: register map, acknowledge FSM states and CTRL bit positions for pic_nchan
package pic_pkg;
  localparam logic [2:0] A_CTRL  = 3'd0;
  localparam logic [2:0] A_VBASE = 3'd1;
  localparam logic [2:0] A_IMR   = 3'd2;
  localparam logic [2:0] A_TRIG  = 3'd3;
  localparam logic [2:0] A_IRR   = 3'd4;
  localparam logic [2:0] A_ISR   = 3'd5;
  localparam logic [2:0] A_EOI   = 3'd6;
  localparam logic [2:0] A_SWINT = 3'd7;
  localparam int C_AEOI = 0;
  localparam int C_ROT  = 1;
  typedef enum logic [1:0] {IDLE, ACK1, ACK2} ack_e;
endpackage

// File: rtl/pic_prio_resolver.sv
// pic_prio_resolver: picks the top-ranked request (fixed or rotating) and tells whether it outranks all in-service bits
module pic_prio_resolver #(
  parameter int N    = 16,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    isr,
  input  logic            rotate,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] win,
  output logic            valid,
  output logic            outranks
);
  logic [ID_W-1:0] ptr_e, ib;
  int idx, req_rank, isr_rank;
  assign ptr_e = rotate ? ptr : ID_W'(N-1);
  // walk from lowest to highest rank so the last hit is the highest-priority channel
  always_comb begin
    win = '0;
    valid = 1'b0;
    req_rank = N;
    isr_rank = N;
    idx = 0;
    ib = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = int'(ptr_e) + 1 + k;
      idx = idx >= N ? idx - N : idx;
      ib = idx[ID_W-1:0];
      if (req[ib]) begin
        win = ib;
        valid = 1'b1;
        req_rank = k;
      end
      if (isr[ib]) isr_rank = k;
    end
  end
  assign outranks = valid && req_rank < isr_rank;
endmodule

// File: rtl/pic_nchan.sv
// pic_nchan: NUM_IRQ-channel 8259-style interrupt controller; define PIC_SWINT_EN to enable the SWINT register at address 7
module pic_nchan
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 16,
  parameter int DATA_W  = 16,
  parameter int VEC_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cs_n,
  input  logic               wr_n,
  input  logic               rd_n,
  input  logic [2:0]         addr,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               inta_n,
  output logic               int_o,
  output logic [VEC_W-1:0]   vec_out,
  output logic               vec_valid
);
  localparam int N = NUM_IRQ;
  localparam int ID_W = $clog2(NUM_IRQ);
  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] s1_q, s2_q, s3_q;
  logic [2:0] ia_q;
  logic [1:0] ctrl_q, ctrl_d;
  logic [VEC_W-ID_W-1:0] vb_q, vb_d;
  logic [N-1:0] imr_q, imr_d, trig_q, trig_d, irr_q, irr_d, isr_q, isr_d;
  logic [ID_W-1:0] ptr_q, ptr_d, win_q, win_d;
  logic spur_q, spur_d, int_q, int_d, vv_q, vv_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  ack_e st_q, st_d;
  logic wr, rd, fall, rise, ack, eoi_wr, eoi_ns, eoi_hit;
  logic [N-1:0] ack_clr, hold, aeoi_clr, isr_clr, sw_or;
  logic [ID_W-1:0] r_win, e_win, eoi_k, spec_k;
  logic r_valid, r_out, e_valid, e_out;

  pic_prio_resolver #(.N(N), .ID_W(ID_W)) u_req (
    .req(irr_q & ~imr_q), .isr(isr_q), .rotate(ctrl_q[C_ROT]), .ptr(ptr_q),
    .win(r_win), .valid(r_valid), .outranks(r_out)
  );

  pic_prio_resolver #(.N(N), .ID_W(ID_W)) u_eoi (
    .req(isr_q), .isr('0), .rotate(ctrl_q[C_ROT]), .ptr(ptr_q),
    .win(e_win), .valid(e_valid), .outranks(e_out)
  );

  assign wr = !cs_n && !wr_n;
  assign rd = !cs_n && !rd_n && wr_n;
  assign fall = ia_q[2] && !ia_q[1];
  assign rise = !ia_q[2] && ia_q[1];
  assign ack = st_q == IDLE && fall && r_valid && r_out;
  assign ack_clr = ack ? ONE << r_win : '0;
  assign hold = (st_q != IDLE && !spur_q) ? ONE << win_q : '0;
  assign eoi_wr = wr && addr == A_EOI;
  assign eoi_ns = data_in[DATA_W-1];
  assign spec_k = data_in[ID_W-1:0];
  assign eoi_k = eoi_ns ? e_win : spec_k;
  assign eoi_hit = eoi_wr && (eoi_ns ? e_valid && e_out : isr_q[spec_k]);
  assign aeoi_clr = (st_q == ACK2 && rise && ctrl_q[C_AEOI] && !spur_q) ? ONE << win_q : '0;
  assign isr_clr = (eoi_hit ? ONE << eoi_k : '0) | aeoi_clr;

`ifdef PIC_SWINT_EN
  logic [N-1:0] sw_q, sw_d, sw_set;
  assign sw_set = (wr && addr == A_SWINT) ? data_in[N-1:0] : '0;
  // level channels would otherwise lose a software request on the next level sample
  always_comb sw_d = (sw_q | (sw_set & trig_q)) & ~ack_clr;
  // software request hold for level-mode channels
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sw_q <= '0;
    else sw_q <= sw_d;
  assign sw_or = sw_set | sw_q;
`else
  assign sw_or = '0;
`endif

  // acknowledge FSM next state: latch winner on first pulse, present vector on second
  always_comb begin
    st_d = st_q;
    win_d = win_q;
    spur_d = spur_q;
    vec_d = vec_q;
    vv_d = vv_q;
    if (st_q == IDLE && fall) begin
      st_d = ACK1;
      win_d = ack ? r_win : ID_W'(N-1);
      spur_d = !ack;
    end else if (st_q == ACK1 && fall) begin
      st_d = ACK2;
      vec_d = {vb_q, win_q};
      vv_d = 1'b1;
    end else if (st_q == ACK2 && rise) begin
      st_d = IDLE;
      vv_d = 1'b0;
    end
  end

  // register bank, request/in-service update and read mux
  always_comb begin
    ctrl_d = (wr && addr == A_CTRL) ? data_in[1:0] : ctrl_q;
    vb_d = (wr && addr == A_VBASE) ? data_in[VEC_W-1:ID_W] : vb_q;
    imr_d = (wr && addr == A_IMR) ? data_in[N-1:0] : imr_q;
    trig_d = (wr && addr == A_TRIG) ? data_in[N-1:0] : trig_q;
    irr_d = ((trig_q & s2_q & ~hold) | (~trig_q & (irr_q | (s2_q & ~s3_q))) | sw_or) & ~ack_clr;
    isr_d = (isr_q | ack_clr) & ~isr_clr;
    ptr_d = (eoi_hit && ctrl_q[C_ROT]) ? eoi_k : ptr_q;
    int_d = r_out && !ack;
    dout_d = !rd ? dout_q :
             addr == A_CTRL  ? DATA_W'(ctrl_q) :
             addr == A_VBASE ? DATA_W'({vb_q, {ID_W{1'b0}}}) :
             addr == A_IMR   ? DATA_W'(imr_q) :
             addr == A_TRIG  ? DATA_W'(trig_q) :
             addr == A_IRR   ? DATA_W'(irr_q) :
             addr == A_ISR   ? DATA_W'(isr_q) : '0;
  end

  // all state, including irq and inta_n synchronisers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      ia_q <= '1;
      ctrl_q <= '0;
      vb_q <= '0;
      imr_q <= '1;
      trig_q <= '0;
      irr_q <= '0;
      isr_q <= '0;
      ptr_q <= '0;
      win_q <= '0;
      spur_q <= 1'b0;
      int_q <= 1'b0;
      vv_q <= 1'b0;
      vec_q <= '0;
      dout_q <= '0;
      st_q <= IDLE;
    end else begin
      s1_q <= irq;
      s2_q <= s1_q;
      s3_q <= s2_q;
      ia_q <= {ia_q[1:0], inta_n};
      ctrl_q <= ctrl_d;
      vb_q <= vb_d;
      imr_q <= imr_d;
      trig_q <= trig_d;
      irr_q <= irr_d;
      isr_q <= isr_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      spur_q <= spur_d;
      int_q <= int_d;
      vv_q <= vv_d;
      vec_q <= vec_d;
      dout_q <= dout_d;
      st_q <= st_d;
    end

  assign data_out = dout_q;
  assign int_o = int_q;
  assign vec_out = vec_q;
  assign vec_valid = vv_q;
endmodule

// File: tb/tb_pic_nchan.sv
// tb_pic_nchan: register table, directed acknowledge scenarios and a randomized run against a priority model
module tb_pic_nchan;
  import pic_pkg::*;
  localparam int N = 16;
  localparam logic [15:0] SW_EXP = `ifdef PIC_SWINT_EN 16'h0001 `else 16'h0000 `endif;

  logic clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, inta_n = 1'b1;
  logic [2:0] addr = '0;
  logic [15:0] data_in = '0, irq = '0, data_out;
  logic int_o, vec_valid;
  logic [7:0] vec_out;
  int n_tests = 0, n_fail = 0;

  typedef struct packed {
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra;
    logic [15:0] ex;
  } vec_t;
  vec_t tbl [11];

  logic [15:0] m_irr, m_isr, m_imr, v, b;
  logic [1:0] m_ctrl;
  int m_ptr, w, t, k;

  pic_nchan dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .addr(addr),
    .data_in(data_in), .data_out(data_out), .irq(irq), .inta_n(inta_n),
    .int_o(int_o), .vec_out(vec_out), .vec_valid(vec_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] ex);
    n_tests++;
    if (got !== ex) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, ex);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; data_in = d;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    cs_n = 1'b0; rd_n = 1'b0; addr = a;
    @(negedge clk);
    cs_n = 1'b1; rd_n = 1'b1;
    d = data_out;
  endtask

  task automatic chk_reg(input string nm, input logic [2:0] a, input logic [15:0] ex);
    logic [15:0] r;
    rd(a, r);
    chk(nm, r, ex);
  endtask

  task automatic pulse(input logic [15:0] bits);
    @(negedge clk);
    irq = bits;
    idle(3);
    irq = '0;
    idle(4);
  endtask

  task automatic inta_lo;
    inta_n = 1'b0;
    idle(5);
  endtask

  task automatic inta_hi;
    inta_n = 1'b1;
    idle(5);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; irq = '0; inta_n = 1'b1; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic ack(input string nm, input logic [7:0] ev);
    inta_lo;
    inta_hi;
    inta_lo;
    chk({nm, " valid"}, 16'(vec_valid), 16'h1);
    chk(nm, 16'(vec_out), 16'(ev));
    inta_hi;
    chk({nm, " valid off"}, 16'(vec_valid), 16'h0);
  endtask

  function automatic int rnk(input int ch, input logic rot, input int p);
    return rot ? (ch - p - 1 + 2*N) % N : ch;
  endfunction

  function automatic int top(input logic [15:0] vv, input logic rot, input int p);
    int best = -1;
    for (int c = 0; c < N; c++)
      if (vv[c] && (best < 0 || rnk(c, rot, p) < rnk(best, rot, p))) best = c;
    return best;
  endfunction

  function automatic logic m_int(input logic rot);
    int a = top(m_irr & ~m_imr, rot, m_ptr);
    int s = top(m_isr, rot, m_ptr);
    return a >= 0 && (s < 0 || rnk(a, rot, m_ptr) < rnk(s, rot, m_ptr));
  endfunction

  initial begin
    tbl[0]  = '{A_CTRL,  16'h0003, A_CTRL,  16'h0003};
    tbl[1]  = '{A_CTRL,  16'hFFFC, A_CTRL,  16'h0000};
    tbl[2]  = '{A_VBASE, 16'h00FF, A_VBASE, 16'h00F0};
    tbl[3]  = '{A_VBASE, 16'h0075, A_VBASE, 16'h0070};
    tbl[4]  = '{A_IMR,   16'h00C2, A_IMR,   16'h00C2};
    tbl[5]  = '{A_TRIG,  16'hA5A5, A_TRIG,  16'hA5A5};
    tbl[6]  = '{A_TRIG,  16'h0000, A_TRIG,  16'h0000};
    tbl[7]  = '{A_EOI,   16'h8000, A_ISR,   16'h0000};
    tbl[8]  = '{A_EOI,   16'h8003, A_EOI,   16'h0000};
    tbl[9]  = '{A_SWINT, 16'h0001, A_IRR,   SW_EXP};
    tbl[10] = '{A_IMR,   16'hFFFF, A_IMR,   16'hFFFF};

    idle(3);
    chk("reset int_o", 16'(int_o), 16'h0);
    chk("reset vec_valid", 16'(vec_valid), 16'h0);
    chk("reset vec_out", 16'(vec_out), 16'h0);
    chk("reset data_out", data_out, 16'h0);
    rst_n = 1'b1;
    idle(2);
    chk_reg("reset IMR", A_IMR, 16'hFFFF);
    chk_reg("reset IRR", A_IRR, 16'h0000);
    chk_reg("reset ISR", A_ISR, 16'h0000);
    chk_reg("reset CTRL", A_CTRL, 16'h0000);
    chk_reg("reset VBASE", A_VBASE, 16'h0000);
    chk_reg("reset TRIG", A_TRIG, 16'h0000);

    for (int i = 0; i < 11; i++) begin
      wr(tbl[i].wa, tbl[i].wd);
      chk_reg($sformatf("tbl%0d", i), tbl[i].ra, tbl[i].ex);
    end

    rd(A_IMR, v);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; addr = A_CTRL; data_in = 16'h0001;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    idle(2);
    chk("wr+rd holds data_out", data_out, 16'hFFFF);
    chk_reg("wr+rd wrote CTRL", A_CTRL, 16'h0001);

    do_reset;
    wr(A_IMR, 16'h0000);
    wr(A_VBASE, 16'h0070);
    pulse(16'h0012);
    chk("fixed int_o", 16'(int_o), 16'h1);
    inta_lo;
    chk_reg("fixed ISR after ack1", A_ISR, 16'h0002);
    chk_reg("fixed IRR after ack1", A_IRR, 16'h0010);
    chk("fixed int_o nested", 16'(int_o), 16'h0);
    inta_hi;
    inta_lo;
    chk("fixed valid", 16'(vec_valid), 16'h1);
    chk("fixed vector", 16'(vec_out), 16'h0071);
    inta_hi;
    chk("fixed valid off", 16'(vec_valid), 16'h0);
    wr(A_EOI, 16'h8000);
    idle(2);
    chk_reg("fixed ISR after eoi", A_ISR, 16'h0000);
    chk("fixed int_o again", 16'(int_o), 16'h1);
    ack("fixed vector2", 8'h74);

    do_reset;
    wr(A_VBASE, 16'h0070);
    wr(A_IMR, 16'h00C2);
    pulse(16'h0096);
    chk_reg("mask IRR", A_IRR, 16'h0096);
    chk_reg("mask IMR", A_IMR, 16'h00C2);
    chk("mask int_o", 16'(int_o), 16'h1);
    ack("mask vector", 8'h72);

    do_reset;
    wr(A_VBASE, 16'h0070);
    wr(A_IMR, 16'h0000);
    wr(A_TRIG, 16'h0001);
    wr(A_CTRL, 16'h0001);
    irq = 16'h0001;
    idle(5);
    chk("level int_o", 16'(int_o), 16'h1);
    inta_lo;
    chk_reg("level IRR held during ack", A_IRR, 16'h0000);
    chk_reg("level ISR during ack", A_ISR, 16'h0001);
    inta_hi;
    inta_lo;
    chk("level vector", 16'(vec_out), 16'h0070);
    inta_hi;
    chk_reg("level aeoi ISR", A_ISR, 16'h0000);
    chk("level int_o reasserts", 16'(int_o), 16'h1);
    irq = '0;
    idle(5);
    chk_reg("level IRR follows", A_IRR, 16'h0000);
    chk("level int_o drops", 16'(int_o), 16'h0);

    do_reset;
    wr(A_VBASE, 16'h0070);
    wr(A_IMR, 16'h0000);
    wr(A_CTRL, 16'h0002);
    pulse(16'h0003);
    ack("rotate first", 8'h71);
    wr(A_EOI, 16'h8000);
    pulse(16'h0002);
    ack("rotate after eoi", 8'h70);
    chk_reg("rotate ISR", A_ISR, 16'h0001);
    chk_reg("rotate IRR", A_IRR, 16'h0002);

    do_reset;
    wr(A_VBASE, 16'h0070);
    wr(A_IMR, 16'h0000);
    pulse(16'h0008);
    chk("spurious int_o before", 16'(int_o), 16'h1);
    wr(A_IMR, 16'h0008);
    idle(2);
    chk("spurious int_o masked", 16'(int_o), 16'h0);
    ack("spurious vector", 8'h7F);
    chk_reg("spurious ISR", A_ISR, 16'h0000);
    chk_reg("spurious IRR", A_IRR, 16'h0008);

    do_reset;
    wr(A_IMR, 16'h0000);
    wr(A_TRIG, 16'h0F00);
    pulse(16'h0004);
    inta_lo;
    inta_hi;
    inta_lo;
    chk("rst mid valid before", 16'(vec_valid), 16'h1);
    #2 rst_n = 1'b0;
    #1 chk("rst mid valid", 16'(vec_valid), 16'h0);
    inta_n = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk_reg("rst mid IRR", A_IRR, 16'h0000);
    chk_reg("rst mid ISR", A_ISR, 16'h0000);
    chk_reg("rst mid IMR", A_IMR, 16'hFFFF);
    chk_reg("rst mid TRIG", A_TRIG, 16'h0000);

    for (int r = 0; r < 4; r++) begin
      do_reset;
      m_ctrl = 2'(r);
      m_irr = '0; m_isr = '0; m_imr = '0; m_ptr = 0;
      wr(A_CTRL, 16'(m_ctrl));
      wr(A_VBASE, 16'h0050);
      wr(A_IMR, 16'h0000);
      for (int i = 0; i < 40; i++) begin
        case ($urandom_range(0, 4))
          0, 1: begin
            b = 16'($urandom & $urandom);
            pulse(b);
            m_irr |= b;
          end
          2: begin
            m_imr = 16'($urandom & $urandom & $urandom);
            wr(A_IMR, m_imr);
          end
          3: begin
            if ($urandom_range(0, 1) == 1) begin
              wr(A_EOI, 16'h8000);
              k = top(m_isr, m_ctrl[1], m_ptr);
            end else begin
              k = int'($urandom_range(0, N-1));
              wr(A_EOI, 16'(k));
              if (!m_isr[k]) k = -1;
            end
            if (k >= 0) begin
              m_isr[k] = 1'b0;
              if (m_ctrl[1]) m_ptr = k;
            end
          end
          default: begin
            w = top(m_irr & ~m_imr, m_ctrl[1], m_ptr);
            t = top(m_isr, m_ctrl[1], m_ptr);
            if (w >= 0 && (t < 0 || rnk(w, m_ctrl[1], m_ptr) < rnk(t, m_ctrl[1], m_ptr))) begin
              m_irr[w] = 1'b0;
              if (!m_ctrl[0]) m_isr[w] = 1'b1;
            end else w = N - 1;
            ack($sformatf("rand r%0d i%0d vector", r, i), 8'h50 | 8'(w));
          end
        endcase
        idle(2);
        chk($sformatf("rand r%0d i%0d int_o", r, i), 16'(int_o), 16'(m_int(m_ctrl[1])));
        chk_reg($sformatf("rand r%0d i%0d IRR", r, i), A_IRR, m_irr);
        chk_reg($sformatf("rand r%0d i%0d ISR", r, i), A_ISR, m_isr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
